filter_scan_ctrl: RTL and testbench

- Scan controller that owns a bank of NUM_CH three-point style input deglitchers and time-shares one comparison datapath across them.
- Generates a programmable sample tick, visits each channel once per tick, updates its filtered level after AGREE consecutive disagreeing samples, and reports every level change as an event.
- Events are queued in a small FIFO with a valid/ready handshake.
- Sits between raw board inputs (buttons, external status lines) and the miner control logic.

---
 rtl/filter_pkg.sv | 19 +
 rtl/filter_scan_ctrl_if.sv | 10 +
 rtl/filter_evt_fifo.sv | 45 ++++
 rtl/filter_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_filter_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared types for the input-deglitch scan controller.
package filter_pkg;

    typedef enum logic {IDLE, SCAN} state_t;

    // Widest channel index the event record must carry (NUM_CH up to 16).
    localparam int CH_W_MAX = 4;

    // Channel index width, at least one bit even for a single channel.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic                level;
    } evt_t;

endpackage

// File: rtl/filter_scan_ctrl_if.sv
// Event stream handshake: the controller drives, the consumer accepts.
interface filter_scan_ctrl_if #(parameter int CH_W = 2);
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_level;

    modport master (output evt_valid, evt_ch, evt_level, input evt_ready);
    modport slave  (input evt_valid, evt_ch, evt_level, output evt_ready);
endinterface

// File: rtl/filter_evt_fifo.sv
// First-word fall-through event queue; a push while full is accepted
// only when a pop frees a slot in the same cycle.
module filter_evt_fifo
    import filter_pkg::*;
#(
    parameter int EVT_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  evt_t din_i,
    input  logic pop_i,
    output evt_t dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(EVT_DEPTH);

    evt_t          mem_q [EVT_DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic          wr_en, rd_en;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset; the pointers gate what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/filter_scan_ctrl.sv
// Deglitch scan controller: one shared compare slot visits each channel
// per sample tick and queues an event on every filtered level change.
module filter_scan_ctrl
    import filter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int AGREE     = 3,
    parameter int EVT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [CNT_W-1:0]     div_cfg,
    input  logic [NUM_CH-1:0]    raw_in,
    output logic [NUM_CH-1:0]    filt_out,
    filter_scan_ctrl_if.master   evt,
    output logic                 evt_drop,
    input  logic                 drop_clr,
    output logic                 busy
);
    localparam int              CH_W    = ch_w(NUM_CH);
    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(NUM_CH);
    localparam logic [2:0]       CNT_TOP = 3'(AGREE - 1);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0]      sync1_q, sync2_q;
    logic [CNT_W-1:0]       pre_q, pre_d, lim;
    logic                   tick;
    state_t                 state_q;
    logic [CH_W-1:0]        ch_q;
    logic [NUM_CH-1:0]      filt_q;
    logic [NUM_CH-1:0][2:0] cnt_q;
    logic                   drop_q;

    logic                   slot_act, cur_in, cur_filt, differ, flip;
    logic [2:0]             cur_cnt;
    evt_t                   push_data, head;
    logic                   fifo_full, fifo_empty, pop, drop;

    // Two-flop synchroniser on every raw input bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Period is clamped to NUM_CH+1 so a tick never lands inside a scan;
    // >= lets a smaller div_cfg take effect mid-count.
    assign lim  = (div_cfg > MIN_LIM) ? div_cfg : MIN_LIM;
    assign tick = enable && (pre_q >= lim);

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (!enable || tick) pre_d = '0;
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

    // Scan FSM: one channel per cycle, NUM_CH cycles per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (tick) begin
                    state_q <= SCAN;
                    ch_q    <= '0;
                end
                SCAN: if (ch_q == LAST_CH) begin
                    state_q <= IDLE;
                    ch_q    <= '0;
                end else begin
                    ch_q <= ch_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Shared compare slot for the channel currently being visited.
    assign slot_act = (state_q == SCAN);
    assign cur_in   = sync2_q[ch_q];
    assign cur_filt = filt_q[ch_q];
    assign cur_cnt  = cnt_q[ch_q];
    assign differ   = cur_in != cur_filt;
    assign flip     = slot_act && differ && (cur_cnt == CNT_TOP);

    // Per-channel agree counter and filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else if (slot_act) begin
            if (!differ) begin
                cnt_q[ch_q] <= '0;
            end else if (flip) begin
                filt_q[ch_q] <= ~cur_filt;
                cnt_q[ch_q]  <= '0;
            end else begin
                cnt_q[ch_q] <= cur_cnt + 1'b1;
            end
        end
    end

    assign push_data = '{ch: CH_W_MAX'(ch_q), level: ~cur_filt};
    assign pop       = !fifo_empty && evt.evt_ready;
    assign drop      = flip && fifo_full && !pop;

    filter_evt_fifo #(.EVT_DEPTH(EVT_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (flip),
        .din_i   (push_data),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sticky overflow flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        drop_q <= 1'b0;
        else if (drop)     drop_q <= 1'b1;
        else if (drop_clr) drop_q <= 1'b0;
    end

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_ch    = head.ch[CH_W-1:0];
    assign evt.evt_level = head.level;
    assign filt_out      = filt_q;
    assign evt_drop      = drop_q;
    assign busy          = slot_act;

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Directed bench with an event scoreboard drained by a handshake monitor.
module tb_filter_scan_ctrl;
    import filter_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CH_W   = ch_w(NUM_CH);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        drop_clr = 1'b0;
    logic [15:0] div_cfg = 16'd9;
    logic [3:0]  raw_in = '0;
    logic [3:0]  filt_out;
    logic        evt_drop, busy;

    filter_scan_ctrl_if #(.CH_W(CH_W)) evt ();

    filter_scan_ctrl #(.NUM_CH(NUM_CH), .CNT_W(16), .AGREE(3), .EVT_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .div_cfg  (div_cfg),
        .raw_in   (raw_in),
        .filt_out (filt_out),
        .evt      (evt.master),
        .evt_drop (evt_drop),
        .drop_clr (drop_clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int lvl; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Every accepted event must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && evt.evt_valid && evt.evt_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL evt_unexpected: got ch %0d level %0d expected none",
                         evt.evt_ch, evt.evt_level);
            end else begin
                mon_e = sb.pop_front();
                chk("evt_ch", int'(evt.evt_ch), mon_e.ch);
                chk("evt_level", int'(evt.evt_level), mon_e.lvl);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (busy) break;
        end
        if (!busy) chk("busy_rise_timeout", 0, 1);
    endtask

    // Counts consecutive negedges (including the current one) at level lvl.
    task automatic count_level(input logic lvl, output int n);
        bit done;
        n = 1;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (busy == lvl) n++;
            else done = 1;
        end
    endtask

    task automatic wait_scan_end();
        int n, h;
        wait_rise(n);
        count_level(1'b1, h);
    endtask

    task automatic wait_filt(input logic [3:0] exp, input string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (filt_out == exp) break;
        end
        chk(nm, int'(filt_out), int'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, h, l, busy_cnt;
        evt.evt_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_filt", int'(filt_out), 0);
        chk("rst_valid", int'(evt.evt_valid), 0);
        chk("rst_drop", int'(evt_drop), 0);
        chk("rst_busy", int'(busy), 0);

        // Tick timing, P = 10: tick in the 10th cycle, busy seen in the 11th
        step();
        enable = 1'b1;
        wait_rise(n);
        chk("first_tick", n, 11);
        count_level(1'b1, h);
        chk("busy_len", h, 4);
        count_level(1'b0, l);
        chk("idle_len", l, 6);
        count_level(1'b1, h);

        // ch2 rises: switches on the third sampling scan
        step();
        raw_in = 4'b0100;
        sb.push_back('{2, 1});
        wait_scan_end();
        chk("rise_scan1", int'(filt_out), 0);
        wait_scan_end();
        chk("rise_scan2", int'(filt_out), 0);
        wait_scan_end();
        chk("rise_scan3", int'(filt_out), 4);
        chk("rise_valid", int'(evt.evt_valid), 1);
        step();
        evt.evt_ready = 1'b1;
        repeat (3) step();
        chk("rise_drained", int'(evt.evt_valid), 0);

        // ch1 glitch for two samples, then a clean rise needs three fresh samples
        wait_scan_end();
        step();
        raw_in[1] = 1'b1;
        wait_scan_end();
        wait_scan_end();
        step();
        raw_in[1] = 1'b0;
        wait_scan_end();
        wait_scan_end();
        chk("glitch_filt", int'(filt_out), 4);
        step();
        raw_in[1] = 1'b1;
        sb.push_back('{1, 1});
        wait_scan_end();
        chk("ch1_scan1", int'(filt_out), 4);
        wait_scan_end();
        chk("ch1_scan2", int'(filt_out), 4);
        wait_scan_end();
        chk("ch1_scan3", int'(filt_out), 6);

        // Clamp: div_cfg=1 still gives a 5-cycle period
        step();
        div_cfg = 16'd1;
        wait_rise(n);
        count_level(1'b1, h);
        count_level(1'b0, l);
        chk("clamp_busy", h, 4);
        chk("clamp_idle", l, 1);
        count_level(1'b1, h);
        chk("clamp_busy2", h, 4);

        // Overflow: 8 events into a 4-deep queue
        step();
        rst_n = 1'b0;
        raw_in = '0;
        evt.evt_ready = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        raw_in = 4'b1111;
        for (int c = 0; c < 4; c++) sb.push_back('{c, 1});
        wait_filt(4'b1111, "ovf_rise");
        step();
        raw_in = 4'b0000;
        wait_filt(4'b0000, "ovf_fall");
        chk("ovf_drop", int'(evt_drop), 1);
        chk("ovf_valid", int'(evt.evt_valid), 1);
        step();
        evt.evt_ready = 1'b1;
        repeat (6) step();
        chk("ovf_drained", int'(evt.evt_valid), 0);
        chk("ovf_sb_empty", sb.size(), 0);
        step();
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        chk("drop_clr", int'(evt_drop), 0);

        // Disable mid-scan: scan completes, no further ticks, filt holds
        wait_scan_end();
        step();
        raw_in = 4'b1111;
        wait_rise(n);
        step();
        enable = 1'b0;
        h = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) h++;
            else break;
        end
        chk("dis_scan_rest", h, 3);
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("dis_no_scan", busy_cnt, 0);
        chk("dis_filt_hold", int'(filt_out), 0);

        // Reset mid-scan with queued events
        step();
        evt.evt_ready = 1'b0;
        enable = 1'b1;
        wait_filt(4'b1111, "prerst_filt");
        chk("prerst_valid", int'(evt.evt_valid), 1);
        wait_rise(n);
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_filt", int'(filt_out), 0);
        chk("mrst_valid", int'(evt.evt_valid), 0);
        chk("mrst_busy", int'(busy), 0);
        step();
        raw_in = '0;
        rst_n = 1'b1;
        evt.evt_ready = 1'b1;
        repeat (5) step();
        chk("post_rst_valid", int'(evt.evt_valid), 0);
        chk("sb_final", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
